uart_loader: RTL and testbench

- Serial program loader sitting directly upstream of the 256x8 system RAM.
- Receives a framed program image over an 8N1 UART line and writes it byte-by-byte into RAM through the RAM write port.
- Holds the CPU in reset until a complete image with a valid checksum has been stored.
- Top level muxes the RAM address/data/write-enable from this block while `cpu_hold` is high, and from the CPU otherwise.

---
 rtl/uart_loader_if.sv | 24 ++
 rtl/uart_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// RAM write port, UART line and loader status grouped as one bundle.
// Latency: none (wires only).
// Backpressure: none; the RAM accepts one write per strobe.
interface uart_loader_if;
  logic       rx;
  logic       we;
  logic [7:0] address;
  logic [7:0] data;
  logic       cpu_hold;
  logic       done;
  logic       err;

  // Loader side: listens to the line, drives the RAM port and status.
  modport master (
    input  rx,
    output we, address, data, cpu_hold, done, err
  );

  // System side: drives the line, observes the RAM port and status.
  modport slave (
    output rx,
    input  we, address, data, cpu_hold, done, err
  );
endinterface

// File: rtl/uart_loader.sv
// Serial program loader: 8N1 UART receiver feeding a length/data/checksum RAM writer.
// Latency: rx is synchronized in 2 cycles; we pulses 1 cycle after the stop-bit sample.
// Backpressure: none; the line cannot be stalled, so every byte is consumed when valid.
module uart_loader #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic         clock,
  input  logic         reset,
  uart_loader_if.master bus
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 2;

  localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);

  // ------------------------------------------------------------------
  // Line synchronizer and falling-edge detect
  // ------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_prev;
  logic rx_fall;

  // Two-flop synchronizer plus one delayed copy for edge detection; idle high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= bus.rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  // ------------------------------------------------------------------
  // Receiver FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  rx_state_t       rs, rs_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            byte_vld;
  logic            frame_err;

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rs      <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rs      <= rs_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Receiver next state: half-bit wait to centre on the start bit, then full-bit steps.
  always_comb begin
    rs_n      = rs;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    case (rs)
      R_IDLE: begin
        if (rx_fall) begin
          rs_n  = R_START;
          cnt_n = HALF_BIT;
        end
      end
      R_START: begin
        if (cnt == '0) begin
          if (!rx_s2) begin
            rs_n      = R_DATA;
            cnt_n     = FULL_BIT;
            bit_idx_n = 3'd0;
          end else begin
            // Line went back high before mid-bit: a glitch, not a start bit.
            rs_n = R_IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      R_DATA: begin
        if (cnt == '0) begin
          shreg_n = {rx_s2, shreg[7:1]};
          cnt_n   = FULL_BIT;
          if (bit_idx == 3'd7) begin
            rs_n = R_STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      R_STOP: begin
        if (cnt == '0) begin
          rs_n      = R_IDLE;
          byte_vld  = rx_s2;
          frame_err = ~rx_s2;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: rs_n = R_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Loader FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    L_WAIT_LEN,
    L_LOAD,
    L_CHECK,
    L_RUN
  } ld_state_t;

  ld_state_t  ls, ls_n;
  logic [8:0] len, len_n;
  logic [7:0] index, index_n;
  logic [7:0] sum, sum_n;
  logic       we_q, we_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] data_q, data_n;
  logic       hold_q, hold_n;
  logic       done_q, done_n;
  logic       err_q, err_n;
  logic [7:0] sum_plus;
  logic       last_byte;

  assign sum_plus  = sum + shreg;
  assign last_byte = (({1'b0, index} + 9'd1) == len);

  // Loader state, image bookkeeping and registered RAM/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      ls     <= L_WAIT_LEN;
      len    <= '0;
      index  <= '0;
      sum    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      hold_q <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ls     <= ls_n;
      len    <= len_n;
      index  <= index_n;
      sum    <= sum_n;
      we_q   <= we_n;
      addr_q <= addr_n;
      data_q <= data_n;
      hold_q <= hold_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  // Loader next state: length byte, N data bytes written to RAM, then checksum byte.
  always_comb begin
    ls_n    = ls;
    len_n   = len;
    index_n = index;
    sum_n   = sum;
    we_n    = 1'b0;
    addr_n  = addr_q;
    data_n  = data_q;
    hold_n  = hold_q;
    done_n  = done_q;
    err_n   = err_q;
    case (ls)
      L_WAIT_LEN: begin
        if (byte_vld) begin
          // Zero encodes a full 256-byte image.
          len_n   = (shreg == 8'd0) ? 9'd256 : {1'b0, shreg};
          index_n = 8'd0;
          sum_n   = 8'd0;
          err_n   = 1'b0;
          ls_n    = L_LOAD;
        end else if (frame_err) begin
          err_n = 1'b1;
        end
      end
      L_LOAD: begin
        if (byte_vld) begin
          we_n    = 1'b1;
          addr_n  = index;
          data_n  = shreg;
          sum_n   = sum_plus;
          index_n = index + 1'b1;
          if (last_byte) begin
            ls_n = L_CHECK;
          end
        end else if (frame_err) begin
          err_n = 1'b1;
          ls_n  = L_WAIT_LEN;
        end
      end
      L_CHECK: begin
        if (byte_vld) begin
          if (sum_plus == 8'd0) begin
            done_n = 1'b1;
            hold_n = 1'b0;
            ls_n   = L_RUN;
          end else begin
            err_n = 1'b1;
            ls_n  = L_WAIT_LEN;
          end
        end else if (frame_err) begin
          err_n = 1'b1;
          ls_n  = L_WAIT_LEN;
        end
      end
      L_RUN: begin
        // Program is live; the line is ignored until the next reset.
      end
      default: ls_n = L_WAIT_LEN;
    endcase
  end

  assign bus.we       = we_q;
  assign bus.address  = addr_q;
  assign bus.data     = data_q;
  assign bus.cpu_hold = hold_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with a write scoreboard (DIV = 16).
// Latency checked: we must appear 155 cycles after the start-bit drive edge.
// Backpressure: none; bytes are sent back to back on the line.
module tb_uart_loader;

  logic clock;
  logic reset;
  int   tests;
  int   fails;
  logic [15:0] sb[$];

  uart_loader_if bus_if ();

  uart_loader #(
    .CLK_FREQ(16),
    .BAUD    (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},   32'(bus_if.we),       32'd0);
    check({tag, "_addr"}, 32'(bus_if.address),  32'd0);
    check({tag, "_data"}, 32'(bus_if.data),     32'd0);
    check({tag, "_hold"}, 32'(bus_if.cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(bus_if.done),     32'd0);
    check({tag, "_err"},  32'(bus_if.err),      32'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    reset = 1'b1;
    bus_if.rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  // Idle line for n cycles; no write may occur.
  task automatic idle(input int n, input string tag);
    int pulses;
    pulses = 0;
    for (int m = 0; m < n; m++) begin
      @(posedge clock); #1;
      if (bus_if.we === 1'b1) pulses++;
      bus_if.rx = 1'b1;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  // One 8N1 frame. Writes are popped from the scoreboard as the DUT makes them.
  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input logic exp_we, input logic [7:0] addr);
    int          pulses;
    int          at;
    logic [9:0]  frame;
    logic [15:0] e;
    pulses = 0;
    at     = -1;
    frame  = {stop, b, 1'b0};
    if (exp_we) sb.push_back({addr, b});
    for (int m = 0; m < 160; m++) begin
      @(posedge clock); #1;
      if (bus_if.we === 1'b1) begin
        pulses++;
        at = m;
        if (sb.size() == 0) begin
          check("we_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(bus_if.address), 32'(e[15:8]));
          check("wr_data", 32'(bus_if.data),    32'(e[7:0]));
        end
      end
      bus_if.rx = frame[m / 16];
    end
    check("we_pulses", 32'(pulses), exp_we ? 32'd1 : 32'd0);
    if (exp_we) check("we_latency", 32'(at), 32'd155);
    if (!stop) begin
      @(posedge clock); #1;
      bus_if.rx = 1'b1;
      repeat (3) @(posedge clock);
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic h, input logic e);
    check({tag, "_done"}, 32'(bus_if.done),     32'(d));
    check({tag, "_hold"}, 32'(bus_if.cpu_hold), 32'(h));
    check({tag, "_err"},  32'(bus_if.err),      32'(e));
  endtask

  task automatic send_abc(input logic [7:0] cs);
    send_byte(8'h03, 1'b1, 1'b0, 8'd0);
    check("abc_len_err", 32'(bus_if.err), 32'd0);
    send_byte(8'h11, 1'b1, 1'b1, 8'd0);
    send_byte(8'h22, 1'b1, 1'b1, 8'd1);
    send_byte(8'h33, 1'b1, 1'b1, 8'd2);
    send_byte(cs,    1'b1, 1'b0, 8'd0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    bus_if.rx = 1'b1;

    // Reset state and quiet line.
    do_reset(3);
    check_reset_vals("rst");
    idle(100, "idle_we");
    check_reset_vals("idle");

    // Good three-byte image.
    send_abc(8'h9A);
    check_status("good", 1'b1, 1'b0, 1'b0);

    // Bad checksum, then the correct image clears err.
    do_reset(2);
    send_abc(8'h9B);
    check_status("badcs", 1'b0, 1'b1, 1'b1);
    send_abc(8'h9A);
    check_status("retry", 1'b1, 1'b0, 1'b0);

    // Framing error inside LOAD, then a fresh length byte.
    do_reset(2);
    send_byte(8'h02, 1'b1, 1'b0, 8'd0);
    send_byte(8'h44, 1'b0, 1'b0, 8'd0);
    check_status("frame", 1'b0, 1'b1, 1'b1);
    send_byte(8'h01, 1'b1, 1'b0, 8'd0);
    check("frame_len_err", 32'(bus_if.err), 32'd0);
    send_byte(8'h55, 1'b1, 1'b1, 8'd0);
    send_byte(8'hAB, 1'b1, 1'b0, 8'd0);
    check_status("frame_ok", 1'b1, 1'b0, 1'b0);

    // Short glitch, then a full 256-byte image.
    do_reset(2);
    @(posedge clock); #1;
    bus_if.rx = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    bus_if.rx = 1'b1;
    idle(50, "glitch_we");
    check("glitch_err", 32'(bus_if.err), 32'd0);
    send_byte(8'h00, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h01, 1'b1, 1'b1, i[7:0]);
    end
    send_byte(8'h00, 1'b1, 1'b0, 8'd0);
    check_status("full", 1'b1, 1'b0, 1'b0);
    check("full_last_addr", 32'(bus_if.address), 32'd255);

    // Reset in the middle of a byte inside LOAD.
    do_reset(2);
    send_byte(8'h04, 1'b1, 1'b0, 8'd0);
    send_byte(8'h01, 1'b1, 1'b1, 8'd0);
    send_byte(8'h02, 1'b1, 1'b1, 8'd1);
    @(posedge clock); #1;
    bus_if.rx = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_vals("midrst");
    reset     = 1'b0;
    bus_if.rx = 1'b1;
    sb.delete();
    idle(20, "midrst_we");
    send_byte(8'h04, 1'b1, 1'b0, 8'd0);
    send_byte(8'h01, 1'b1, 1'b1, 8'd0);
    send_byte(8'h02, 1'b1, 1'b1, 8'd1);
    send_byte(8'h03, 1'b1, 1'b1, 8'd2);
    send_byte(8'h04, 1'b1, 1'b1, 8'd3);
    send_byte(8'hF6, 1'b1, 1'b0, 8'd0);
    check_status("fresh", 1'b1, 1'b0, 1'b0);

    // RUN ignores the line.
    send_byte(8'h77, 1'b1, 1'b0, 8'd0);
    send_byte(8'h00, 1'b0, 1'b0, 8'd0);
    check_status("run", 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
